// File: rtl/stream_mux_arb_pkg.sv
// mux_pkg: shared types for the stream_mux_arb block.
//   mux_mode_t  : arbitration mode (forced select or round-robin)
//   mux_state_t : packet-lock FSM state
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } mux_state_t;

endpackage

// File: rtl/stream_mux_arb_rr_pick.sv
// rr_pick: rotating-priority request search.
//   req   : per-channel request vector
//   ptr   : last-served channel; search starts at ptr+1 and wraps
//   idx   : selected channel (0 when nothing is requested)
//   found : high when any request is set
module rr_pick #(
  parameter  int unsigned NUM_CH = 3,
  localparam int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  idx,
  output logic              found
);

  // Two passes: channels above ptr first, then the wrapped range 0..ptr.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (!found && (c > int'(ptr)) && req[c]) begin
        found = 1'b1;
        idx   = SEL_W'(c);
      end
    end
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (!found && (c <= int'(ptr)) && req[c]) begin
        found = 1'b1;
        idx   = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// stream_mux_arb: registered N-to-1 stream multiplexer with packet locking.
//   clk, reset_n           : clock, asynchronous active-low reset
//   mode, sel              : 0 = forced select via sel, 1 = round-robin
//   in_data/valid/last     : packed per-channel input streams
//   in_ready               : per-channel accept (combinational)
//   out_data/valid/last/ch : registered output word and its source channel
//   out_ready              : consumer accept
module stream_mux_arb
  import mux_pkg::*;
#(
  parameter  int unsigned WORD_SIZE = 16,
  parameter  int unsigned NUM_CH    = 3,
  localparam int unsigned SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        mode,
  input  logic [SEL_W-1:0]            sel,
  input  logic [NUM_CH*WORD_SIZE-1:0] in_data,
  input  logic [NUM_CH-1:0]           in_valid,
  input  logic [NUM_CH-1:0]           in_last,
  output logic [NUM_CH-1:0]           in_ready,
  output logic [WORD_SIZE-1:0]        out_data,
  output logic                        out_valid,
  output logic                        out_last,
  output logic [SEL_W-1:0]            out_ch,
  input  logic                        out_ready
);

  mux_state_t r_state, w_state_next;

  logic [SEL_W-1:0]     r_lock_ch;
  logic [SEL_W-1:0]     r_rr_ptr;
  logic [WORD_SIZE-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic [SEL_W-1:0]     r_out_ch;

  logic [SEL_W-1:0]     w_rr_idx;
  logic                 w_rr_found;
  logic [SEL_W-1:0]     w_grant;
  logic                 w_grant_valid;
  logic                 w_sel_ok;
  logic                 w_accept;
  logic                 w_xfer;
  logic                 w_xfer_last;
  logic [WORD_SIZE-1:0] w_xfer_data;

  rr_pick #(
    .NUM_CH (NUM_CH)
  ) u_rr_pick (
    .req   (in_valid),
    .ptr   (r_rr_ptr),
    .idx   (w_rr_idx),
    .found (w_rr_found)
  );

  assign w_accept = !r_out_valid || out_ready;
  assign w_sel_ok = (32'(sel) < NUM_CH);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: a non-last word opens a lock, a last word closes it
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_xfer && !w_xfer_last) w_state_next = ST_LOCKED;
      ST_LOCKED: if (w_xfer &&  w_xfer_last) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: grant selection and per-channel ready
  always_comb begin
    w_grant       = '0;
    w_grant_valid = 1'b0;
    case (r_state)
      ST_LOCKED: begin
        // Locked channel keeps the grant even while its valid is low.
        w_grant       = r_lock_ch;
        w_grant_valid = 1'b1;
      end
      default: begin
        if (mux_mode_t'(mode) == MODE_RR) begin
          w_grant       = w_rr_idx;
          w_grant_valid = w_rr_found;
        end else begin
          w_grant       = sel;
          w_grant_valid = w_sel_ok;
        end
      end
    endcase
    in_ready = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (w_accept && w_grant_valid && (SEL_W'(i) == w_grant)) in_ready[i] = 1'b1;
    end
  end

  // At most one in_ready bit is set, so this picks the transferring channel.
  always_comb begin
    w_xfer      = 1'b0;
    w_xfer_last = 1'b0;
    w_xfer_data = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (in_ready[i] && in_valid[i]) begin
        w_xfer      = 1'b1;
        w_xfer_last = in_last[i];
        w_xfer_data = in_data[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // Lock channel and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_ch <= '0;
      r_rr_ptr  <= SEL_W'(NUM_CH - 1);
    end else if (w_xfer) begin
      r_lock_ch <= w_grant;
      if (w_xfer_last) r_rr_ptr <= w_grant;
    end
  end

  // Output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
    end else if (w_xfer) begin
      r_out_data  <= w_xfer_data;
      r_out_valid <= 1'b1;
      r_out_last  <= w_xfer_last;
      r_out_ch    <= w_grant;
    end else if (w_accept) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_arb.sv
module tb_stream_mux_arb;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned NUM_CH    = 3;

  logic        clk;
  logic        reset_n;
  logic        mode;
  logic [1:0]  sel;
  logic [47:0] in_data;
  logic [2:0]  in_valid;
  logic [2:0]  in_last;
  logic [2:0]  in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_ch;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  stream_mux_arb #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_CH    (NUM_CH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [2:0]  v;
    logic [2:0]  l;
    logic        ordy;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [2:0]  eir;
    logic        eov;
    logic [15:0] edata;
    logic [1:0]  ech;
    logic        elast;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle: check in_ready before the edge, registered outputs after it.
  task automatic step(input logic m, input logic [1:0] s, input logic [2:0] v,
                      input logic [2:0] l, input logic ordy,
                      input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                      input logic [2:0] eir, input logic eov, input logic [15:0] edata,
                      input logic [1:0] ech, input logic elast, input string tag);
    mode      = m;
    sel       = s;
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
    in_data   = {d2, d1, d0};
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(eir));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
    if (eov) begin
      chk({tag, ".out_data"}, 32'(out_data), 32'(edata));
      chk({tag, ".out_ch"}, 32'(out_ch), 32'(ech));
      chk({tag, ".out_last"}, 32'(out_last), 32'(elast));
    end
  endtask

  initial begin
    // Fixed select, out-of-range select, round-robin rotation, backpressure.
    tbl[0]  = '{1'b0, 2'd1, 3'b010, 3'b010, 1'b1, 16'h0000, 16'h00AA, 16'h0000,
                3'b010, 1'b1, 16'h00AA, 2'd1, 1'b1};
    tbl[1]  = '{1'b0, 2'd3, 3'b111, 3'b111, 1'b1, 16'h1111, 16'h2222, 16'h3333,
                3'b000, 1'b0, 16'h0000, 2'd0, 1'b0};
    tbl[2]  = tbl[1];
    tbl[3]  = '{1'b0, 2'd3, 3'b111, 3'b111, 1'b0, 16'h1111, 16'h2222, 16'h3333,
                3'b000, 1'b0, 16'h0000, 2'd0, 1'b0};
    tbl[4]  = '{1'b0, 2'd2, 3'b100, 3'b100, 1'b1, 16'h0000, 16'h0000, 16'h0202,
                3'b100, 1'b1, 16'h0202, 2'd2, 1'b1};
    tbl[5]  = '{1'b1, 2'd0, 3'b111, 3'b111, 1'b1, 16'h0A05, 16'h0B05, 16'h0C05,
                3'b001, 1'b1, 16'h0A05, 2'd0, 1'b1};
    tbl[6]  = '{1'b1, 2'd0, 3'b111, 3'b111, 1'b1, 16'h0A06, 16'h0B06, 16'h0C06,
                3'b010, 1'b1, 16'h0B06, 2'd1, 1'b1};
    tbl[7]  = '{1'b1, 2'd0, 3'b111, 3'b111, 1'b1, 16'h0A07, 16'h0B07, 16'h0C07,
                3'b100, 1'b1, 16'h0C07, 2'd2, 1'b1};
    tbl[8]  = '{1'b1, 2'd0, 3'b111, 3'b111, 1'b1, 16'h0A08, 16'h0B08, 16'h0C08,
                3'b001, 1'b1, 16'h0A08, 2'd0, 1'b1};
    tbl[9]  = '{1'b1, 2'd0, 3'b111, 3'b111, 1'b1, 16'h0A09, 16'h0B09, 16'h0C09,
                3'b010, 1'b1, 16'h0B09, 2'd1, 1'b1};
    tbl[10] = '{1'b1, 2'd0, 3'b111, 3'b111, 1'b1, 16'h0A0A, 16'h0B0A, 16'h0C0A,
                3'b100, 1'b1, 16'h0C0A, 2'd2, 1'b1};
    for (int i = 11; i < 16; i++) begin
      tbl[i] = '{1'b1, 2'd0, 3'b111, 3'b111, 1'b0, 16'hEEEE, 16'hEEEE, 16'hEEEE,
                 3'b000, 1'b1, 16'h0C0A, 2'd2, 1'b1};
    end
    tbl[16] = '{1'b1, 2'd0, 3'b111, 3'b111, 1'b1, 16'h0A10, 16'h0B10, 16'h0C10,
                3'b001, 1'b1, 16'h0A10, 2'd0, 1'b1};
    tbl[17] = '{1'b1, 2'd0, 3'b000, 3'b000, 1'b1, 16'h0A11, 16'h0B11, 16'h0C11,
                3'b000, 1'b0, 16'h0000, 2'd0, 1'b0};

    reset_n   = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.out_data", 32'(out_data), 32'd0);
    chk("reset.out_ch", 32'(out_ch), 32'd0);
    chk("reset.out_last", 32'(out_last), 32'd0);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].mode, tbl[i].sel, tbl[i].v, tbl[i].l, tbl[i].ordy,
           tbl[i].d0, tbl[i].d1, tbl[i].d2,
           tbl[i].eir, tbl[i].eov, tbl[i].edata, tbl[i].ech, tbl[i].elast,
           $sformatf("vec%0d", i));
    end

    // Fresh reset so round-robin starts at ch0, then a 4-word locked packet on ch0
    // with a 2-cycle gap while ch2 is valid throughout.
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    step(1'b1, 2'd0, 3'b101, 3'b100, 1'b1, 16'h5001, 16'h0000, 16'h7777,
         3'b001, 1'b1, 16'h5001, 2'd0, 1'b0, "lock.w1");
    step(1'b0, 2'd3, 3'b101, 3'b100, 1'b1, 16'h5002, 16'h0000, 16'h7777,
         3'b001, 1'b1, 16'h5002, 2'd0, 1'b0, "lock.w2");
    step(1'b0, 2'd3, 3'b100, 3'b100, 1'b1, 16'h0000, 16'h0000, 16'h7777,
         3'b001, 1'b0, 16'h0000, 2'd0, 1'b0, "lock.gap1");
    step(1'b1, 2'd0, 3'b100, 3'b100, 1'b1, 16'h0000, 16'h0000, 16'h7777,
         3'b001, 1'b0, 16'h0000, 2'd0, 1'b0, "lock.gap2");
    step(1'b1, 2'd0, 3'b101, 3'b100, 1'b1, 16'h5003, 16'h0000, 16'h7777,
         3'b001, 1'b1, 16'h5003, 2'd0, 1'b0, "lock.w3");
    step(1'b1, 2'd0, 3'b101, 3'b101, 1'b1, 16'h5004, 16'h0000, 16'h7777,
         3'b001, 1'b1, 16'h5004, 2'd0, 1'b1, "lock.w4");
    step(1'b1, 2'd0, 3'b101, 3'b101, 1'b1, 16'h6000, 16'h0000, 16'h7777,
         3'b100, 1'b1, 16'h7777, 2'd2, 1'b1, "lock.next");

    // Lock on ch1, then asynchronous reset mid-packet.
    step(1'b1, 2'd0, 3'b010, 3'b000, 1'b1, 16'h0000, 16'h1234, 16'h0000,
         3'b010, 1'b1, 16'h1234, 2'd1, 1'b0, "rst.w1");
    step(1'b1, 2'd0, 3'b011, 3'b000, 1'b1, 16'h9999, 16'h1235, 16'h0000,
         3'b010, 1'b1, 16'h1235, 2'd1, 1'b0, "rst.w2");
    reset_n = 1'b0;
    #1;
    chk("rst.async.out_valid", 32'(out_valid), 32'd0);
    chk("rst.async.out_data", 32'(out_data), 32'd0);
    chk("rst.async.out_ch", 32'(out_ch), 32'd0);
    #3;
    reset_n = 1'b1;
    step(1'b1, 2'd0, 3'b111, 3'b111, 1'b1, 16'h00A1, 16'h00B1, 16'h00C1,
         3'b001, 1'b1, 16'h00A1, 2'd0, 1'b1, "rst.after");
    step(1'b1, 2'd0, 3'b111, 3'b111, 1'b1, 16'h00A2, 16'h00B2, 16'h00C2,
         3'b010, 1'b1, 16'h00B2, 2'd1, 1'b1, "rst.after2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
